// File: rtl/la_pkg.sv
// Shared types and defaults for the logic-analyzer capture path.
package la_pkg;

  localparam int DEFAULT_ADDR_WIDTH = 12;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRE,
    ARM,
    WAIT_TRIG,
    POST,
    DONE
  } capture_state_t;

  function automatic logic is_write_state(input capture_state_t s);
    return (s == PRE) || (s == ARM) || (s == WAIT_TRIG) || (s == POST);
  endfunction

endpackage

// File: rtl/capture_sequencer_if.sv
// Trigger handshake and sample-RAM write port between the sequencer and its peers.
interface capture_sequencer_if
  import la_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) ();

  logic                  valid;
  logic                  trig_run;
  logic                  load_trigs;
  logic                  arm;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;

  modport master (
    input  valid,
    input  trig_run,
    output load_trigs,
    output arm,
    output wr_en,
    output wr_addr
  );

  modport slave (
    output valid,
    output trig_run,
    input  load_trigs,
    input  arm,
    input  wr_en,
    input  wr_addr
  );

endinterface

// File: rtl/capture_window_counter.sv
// Loadable write counter; flags the write that completes the current window.
module capture_window_counter #(
  parameter int WIDTH = 12
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic             last_write
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

  // limit is never zero while inc can be asserted
  assign last_write = inc && (count == (limit - WIDTH'(1)));

endmodule

// File: rtl/capture_sequencer.sv
// Sequences one acquisition: load trigger, pre window, arm, wait for run, post window.
module capture_sequencer
  import la_pkg::*;
#(
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] pre_count,
  input  logic [ADDR_WIDTH-1:0] post_count,
  capture_sequencer_if.master   cap,
  output logic [ADDR_WIDTH-1:0] trig_addr,
  output logic                  busy,
  output logic                  done
);

  capture_state_t        state;
  capture_state_t        state_next;
  logic [ADDR_WIDTH-1:0] pre_q;
  logic [ADDR_WIDTH-1:0] post_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [ADDR_WIDTH-1:0] limit;
  logic                  load_q;
  logic                  arm_q;
  logic                  wr_en_q;
  logic                  trig_run_q;
  logic                  accept;
  logic                  active;
  logic                  trig_event;
  logic                  cnt_clear;
  logic                  cnt_inc;
  logic                  last_write;

  assign active     = !(state == IDLE || state == DONE);
  assign accept     = start && !abort && !active;
  assign trig_event = (state == WAIT_TRIG) && cap.trig_run && !trig_run_q;
  assign cnt_clear  = accept || trig_event;
  assign cnt_inc    = wr_en_q && (state == PRE || state == POST);
  assign limit      = (state == POST) ? post_q : pre_q;

  capture_window_counter #(
    .WIDTH (ADDR_WIDTH)
  ) u_window (
    .clock      (clock),
    .reset_n    (reset_n),
    .clear      (cnt_clear),
    .inc        (cnt_inc),
    .limit      (limit),
    .last_write (last_write)
  );

  always_comb begin
    state_next = state;
    if (abort && active) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (accept) state_next = LOAD;
        LOAD:       state_next = (pre_q != '0) ? PRE : ARM;
        PRE:        if (last_write) state_next = ARM;
        ARM:        state_next = WAIT_TRIG;
        WAIT_TRIG:  if (trig_event) state_next = (post_q == '0) ? DONE : POST;
        POST:       if (last_write) state_next = DONE;
        default:    state_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from state_next, so wr_en/wr_addr on the port
  // line up with the state they are shown in; window counts use that write.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      load_q     <= 1'b0;
      arm_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_run_q <= 1'b0;
      pre_q      <= '0;
      post_q     <= '0;
      wr_addr_q  <= '0;
      trig_addr  <= '0;
    end else begin
      state      <= state_next;
      load_q     <= (state_next == LOAD);
      arm_q      <= (state_next == ARM);
      wr_en_q    <= cap.valid && is_write_state(state_next);
      busy       <= !(state_next == IDLE || state_next == DONE);
      done       <= (state_next == DONE);
      trig_run_q <= cap.trig_run;
      if (accept) begin
        pre_q     <= pre_count;
        post_q    <= post_count;
        wr_addr_q <= '0;
      end else if (wr_en_q) begin
        wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
      end
      if (trig_event) begin
        trig_addr <= wr_addr_q;
      end
    end
  end

  assign cap.load_trigs = load_q;
  assign cap.arm        = arm_q;
  assign cap.wr_en      = wr_en_q;
  assign cap.wr_addr    = wr_addr_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: 12-bit and 4-bit instances share stimulus.
module tb_capture_sequencer;
  import la_pkg::*;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        abort;
  logic [11:0] pre_count;
  logic [11:0] post_count;
  logic        valid;
  logic        trig_run;

  logic [11:0] trig_addr_w;
  logic        busy_w;
  logic        done_w;
  logic [3:0]  trig_addr_n;
  logic        busy_n;
  logic        done_n;

  int checks;
  int failures;

  capture_sequencer_if #(.ADDR_WIDTH(12)) bus_w ();
  capture_sequencer_if #(.ADDR_WIDTH(4))  bus_n ();

  assign bus_w.valid    = valid;
  assign bus_w.trig_run = trig_run;
  assign bus_n.valid    = valid;
  assign bus_n.trig_run = trig_run;

  capture_sequencer #(.ADDR_WIDTH(12)) dut_w (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .pre_count  (pre_count),
    .post_count (post_count),
    .cap        (bus_w),
    .trig_addr  (trig_addr_w),
    .busy       (busy_w),
    .done       (done_w)
  );

  capture_sequencer #(.ADDR_WIDTH(4)) dut_n (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .pre_count  (pre_count[3:0]),
    .post_count (post_count[3:0]),
    .cap        (bus_n),
    .trig_addr  (trig_addr_n),
    .busy       (busy_n),
    .done       (done_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all_low(input string tag);
    check({tag, "_wr_en"}, bus_w.wr_en, 0);
    check({tag, "_arm"}, bus_w.arm, 0);
    check({tag, "_load"}, bus_w.load_trigs, 0);
    check({tag, "_busy"}, busy_w, 0);
    check({tag, "_done"}, done_w, 0);
  endtask

  // Every cycle k below: checks read registers updated at the edge that opened
  // cycle k; inputs changed afterwards are sampled at the edge closing cycle k.
  initial begin
    checks     = 0;
    failures   = 0;
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    pre_count  = '0;
    post_count = '0;
    valid      = 1'b0;
    trig_run   = 1'b0;

    tick;
    tick;
    check_all_low("rst");
    check("rst_addr", bus_w.wr_addr, 0);
    check("rst_taddr", trig_addr_w, 0);
    reset_n = 1'b1;
    tick;
    check_all_low("idle");

    // pre=3 post=2, valid every cycle
    start = 1'b1; pre_count = 12'd3; post_count = 12'd2; valid = 1'b1;
    tick;
    check("B_load", bus_w.load_trigs, 1);
    check("B_busy", busy_w, 1);
    check("B_load_nowr", bus_w.wr_en, 0);
    start = 1'b0;
    for (int c = 2; c <= 12; c++) begin
      tick;
      check("B_wr_en", bus_w.wr_en, 1);
      check("B_addr", bus_w.wr_addr, c - 2);
      check("B_arm", bus_w.arm, (c == 5) ? 1 : 0);
      check("B_done_low", done_w, 0);
      if (c == 10) trig_run = 1'b1;
    end
    tick;
    check("B_done", done_w, 1);
    check("B_busy_end", busy_w, 0);
    check("B_wr_end", bus_w.wr_en, 0);
    check("B_taddr", trig_addr_w, 8);
    trig_run = 1'b0;
    tick;
    check("B_done_sticky", done_w, 1);

    // pre=0 post=0
    start = 1'b1; pre_count = 12'd0; post_count = 12'd0;
    tick;
    check("C_load", bus_w.load_trigs, 1);
    check("C_done_clr", done_w, 0);
    start = 1'b0;
    tick;
    check("C_arm", bus_w.arm, 1);
    check("C_arm_wr", bus_w.wr_en, 1);
    check("C_arm_addr", bus_w.wr_addr, 0);
    tick;
    check("C_wait_addr", bus_w.wr_addr, 1);
    trig_run = 1'b1;
    tick;
    check("C_done", done_w, 1);
    check("C_no_post", bus_w.wr_en, 0);
    check("C_taddr", trig_addr_w, 1);
    trig_run = 1'b0;

    // abort in WAIT_TRIG; trig_run already high on entry is not an event
    start = 1'b1; pre_count = 12'd2; post_count = 12'd1;
    tick;
    start = 1'b0;
    tick;
    check("D_pre_addr", bus_w.wr_addr, 0);
    trig_run = 1'b1;
    tick;
    tick;
    check("D_arm", bus_w.arm, 1);
    tick;
    tick;
    check("D_wait_addr", bus_w.wr_addr, 4);
    check("D_no_event", trig_addr_w, 1);
    check("D_busy", busy_w, 1);
    abort = 1'b1;
    tick;
    check_all_low("D_abort");
    check("D_taddr_kept", trig_addr_w, 1);
    start = 1'b1;
    tick;
    check_all_low("D_start_abort");
    start = 1'b0; abort = 1'b0; trig_run = 1'b0;
    tick;
    check("D_still_idle", busy_w, 0);

    // valid toggling in POST, trig_run re-pulsed during POST
    start = 1'b1; pre_count = 12'd1; post_count = 12'd3;
    tick;
    start = 1'b0;
    tick;
    tick;
    check("E_arm", bus_w.arm, 1);
    tick;
    check("E_wait_addr", bus_w.wr_addr, 2);
    trig_run = 1'b1;
    tick;
    check("E_p1_wr", bus_w.wr_en, 1);
    check("E_p1_addr", bus_w.wr_addr, 3);
    valid = 1'b0;
    tick;
    check("E_gap1", bus_w.wr_en, 0);
    valid = 1'b1; trig_run = 1'b0;
    tick;
    check("E_p2_wr", bus_w.wr_en, 1);
    check("E_p2_addr", bus_w.wr_addr, 4);
    valid = 1'b0; trig_run = 1'b1;
    tick;
    check("E_gap2", bus_w.wr_en, 0);
    check("E_not_done", done_w, 0);
    valid = 1'b1;
    tick;
    check("E_p3_wr", bus_w.wr_en, 1);
    check("E_p3_addr", bus_w.wr_addr, 5);
    tick;
    check("E_done", done_w, 1);
    check("E_wr_end", bus_w.wr_en, 0);
    check("E_taddr", trig_addr_w, 2);
    check("E_addr_end", bus_w.wr_addr, 6);
    trig_run = 1'b0;

    // 4-bit address wrap: pre=2, trigger after 20 valid samples in WAIT_TRIG
    start = 1'b1; pre_count = 12'd2; post_count = 12'd1;
    tick;
    start = 1'b0;
    for (int c = 2; c <= 25; c++) begin
      tick;
      check("F_addr_n", bus_n.wr_addr, (c - 2) % 16);
      check("F_wr_n", bus_n.wr_en, 1);
    end
    trig_run = 1'b1;
    tick;
    check("F_post_addr_n", bus_n.wr_addr, 8);
    tick;
    check("F_done_n", done_n, 1);
    check("F_busy_n", busy_n, 0);
    check("F_taddr_n", trig_addr_n, 7);
    check("F_taddr_w", trig_addr_w, 23);
    trig_run = 1'b0;

    // reset asserted mid-POST
    start = 1'b1; pre_count = 12'd1; post_count = 12'd5;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    trig_run = 1'b1;
    tick;
    check("G_busy_post", busy_w, 1);
    check("G_post_wr", bus_w.wr_en, 1);
    reset_n = 1'b0;
    tick;
    check_all_low("G_rst");
    check("G_addr", bus_w.wr_addr, 0);
    check("G_taddr", trig_addr_w, 0);
    reset_n = 1'b1; trig_run = 1'b0; valid = 1'b0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/capture_sequencer.md
Name: capture_sequencer

Overview:
- Capture-side controller for the logic analyzer. Sequences one acquisition: loads the trigger configuration, fills a pre-trigger window, arms the per-channel trigger, waits for its run pulse, then collects a post-trigger window.
- Drives the sample-buffer write port as a circular buffer and reports the trigger address to the host interface.
- Sits between the host command/register block, the basic trigger, and the sample RAM.

Parameters:
- ADDR_WIDTH, 12, sample-buffer address width; depth = 2**ADDR_WIDTH; also the width of both window counts.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; begins an acquisition from IDLE
- abort  in  1  one-cycle pulse; cancels any acquisition in progress
- pre_count  in  ADDR_WIDTH  pre-trigger sample count; latched on accepted start
- post_count  in  ADDR_WIDTH  post-trigger sample count; latched on accepted start
- valid  in  1  sample strobe shared with the trigger
- trig_run  in  1  run output from the trigger
- load_trigs  out  1  one-cycle load strobe to the trigger
- arm  out  1  one-cycle arm strobe to the trigger
- wr_en  out  1  sample RAM write enable
- wr_addr  out  ADDR_WIDTH  sample RAM write address
- trig_addr  out  ADDR_WIDTH  wr_addr value captured at trigger detection
- busy  out  1  high in any state other than IDLE or DONE
- done  out  1  sticky completion flag; cleared by the next accepted start

Behaviour:
- Reset: all outputs 0, state IDLE, internal counters 0. Reset overrides everything, including mid-acquisition.
- States: IDLE, LOAD, PRE, ARM, WAIT_TRIG, POST, DONE. All outputs are registered.
- Write rule: wr_en = valid in PRE, ARM, WAIT_TRIG and POST; otherwise 0.
- Address rule: wr_addr increments by 1 after each write and wraps modulo 2**ADDR_WIDTH.
- IDLE or DONE, start=1 and abort=0:
  - Latch pre_count and post_count; clear wr_addr, counters and done.
  - Go to LOAD.
- LOAD (exactly 1 cycle): load_trigs=1, no write.
  - Next state: PRE if latched pre_count != 0, else ARM.
- PRE: counts writes. When the write that brings the count to pre_count occurs, go to ARM on the next cycle. The trigger is not armed, so trig_run is ignored.
- ARM (exactly 1 cycle): arm=1; a valid sample in this cycle is written (no capture gap). Next state: WAIT_TRIG.
- WAIT_TRIG: unbounded, and the buffer overwrites circularly.
  - Trigger event = trig_run & !trig_run_q, where trig_run_q is the 1-cycle delayed copy. A held-high trig_run during valid gaps is one event, not several.
  - On the event: trig_addr <= current wr_addr. A sample written in the same cycle belongs to the pre window and is not counted as post.
  - Next state: POST, or DONE if latched post_count == 0.
- POST: counts writes; after post_count writes go to DONE. Further trig_run events are ignored.
- DONE: done=1 and busy=0; holds until an accepted start.
- Window sizing: pre_count + post_count > depth is not checked; the oldest samples are overwritten.
- abort in any state other than IDLE or DONE:
  - Next cycle: IDLE, wr_en=0, done stays 0, trig_addr unchanged.
- Simultaneous start and abort: abort wins and start is ignored.
- start is ignored in every state other than IDLE and DONE.
- Latency:
  - start to load_trigs: 1 cycle.
  - trig_run rising edge to POST state: 1 cycle.
  - Final post write to done=1: 1 cycle.

Decomposition:
- Shared package la_pkg:
  - capture_state_t enum (IDLE, LOAD, PRE, ARM, WAIT_TRIG, POST, DONE).
  - DEFAULT_ADDR_WIDTH = 12.
- One sub-module: capture_window_counter. A loadable write counter with a terminal-count flag, instantiated once and reused for the PRE and POST phases.
- The address counter and edge detector stay inline.

Test Plan:
- Reset asserted mid-POST -> next cycle state IDLE; wr_en=0, arm=0, load_trigs=0, busy=0, done=0.
- ADDR_WIDTH=12, pre=3, post=2, valid every cycle; trig_run rises 4 cycles after arm -> load_trigs 1 cycle after start; PRE writes addr 0,1,2; arm=1 while writing addr 3; 4 writes in WAIT_TRIG; trig_addr=8 with addr 8 written as pre; POST writes addr 9,10; done=1 one cycle later.
- pre=0, post=0 -> LOAD goes straight to ARM; after the trig_run edge, DONE with zero POST writes and done=1.
- ADDR_WIDTH=4, pre=2, trigger after 20 valid samples in WAIT_TRIG -> wr_addr wraps 15->0; trig_addr=(2+1+20) mod 16 = 7.
- abort in WAIT_TRIG, then start in the same cycle as a second abort -> IDLE, done stays 0; second start ignored.
- valid toggling 1-0-1 in POST with trig_run held high, post=3 -> exactly 3 writes, a single trig_addr capture, done after the 3rd write.
